// File: rtl/uart_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_sender : async serial transmitter, 8 data bits, LSB first,          |
// |               optional parity and 1 or 2 stop bits                       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_sender #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TX_EN,
  input  logic [7:0] TX_DATA,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int             c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int             c_CNT_W        = $clog2(c_CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [2:0]     c_LAST_STOP    = 3'(STOP_BITS - 1);
  localparam logic           c_HAS_PARITY   = (PARITY != 0);
  localparam logic           c_ODD          = (PARITY == 2);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_tx;
  logic               r_status;
  logic               w_bit_end;

  assign w_bit_end = (r_cnt == c_CNT_MAX);
  assign UART_TX   = r_tx;
  assign TX_STATUS = r_status;

  // Line value for the next bit is loaded on the edge that ends the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_status  <= 1'b1;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (TX_EN) begin
            r_shift   <= TX_DATA;
            r_parity  <= (^TX_DATA) ^ c_ODD;
            r_state   <= c_START;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_status  <= 1'b0;
          end
        end
        c_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= c_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              if (c_HAS_PARITY) begin
                r_state <= c_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= c_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= c_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == c_LAST_STOP) begin
              r_bit_idx <= '0;
              r_state   <= c_IDLE;
              r_status  <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= c_IDLE;
          r_cnt    <= '0;
          r_tx     <= 1'b1;
          r_status <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_sender : scoreboard bench for uart_sender, 16 clocks per bit     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_uart_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tx_en = 4'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] st;
  logic [3:0] tx;
  logic [1:0] sel = 2'd0;
  logic       mon_tx;
  logic       mon_status;

  int n_chk = 0;
  int n_err = 0;

  // Expected line value per bit slot, in transmit order, as '0'/'1' characters.
  string exp_q[$];
  int    gap_q[$];
  int    abort_q[$];

  always #5 clk = ~clk;

  assign mon_tx     = tx[sel];
  assign mon_status = st[sel];

  // 0: no parity/1 stop, 1: even/1 stop, 2: odd/1 stop, 3: no parity/2 stop
  uart_sender #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst_n(rst_n), .TX_EN(tx_en[0]), .TX_DATA(tx_data),
    .TX_STATUS(st[0]), .UART_TX(tx[0]));
  uart_sender #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_pe (
    .clk(clk), .rst_n(rst_n), .TX_EN(tx_en[1]), .TX_DATA(tx_data),
    .TX_STATUS(st[1]), .UART_TX(tx[1]));
  uart_sender #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_po (
    .clk(clk), .rst_n(rst_n), .TX_EN(tx_en[2]), .TX_DATA(tx_data),
    .TX_STATUS(st[2]), .UART_TX(tx[2]));
  uart_sender #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .TX_EN(tx_en[3]), .TX_DATA(tx_data),
    .TX_STATUS(st[3]), .UART_TX(tx[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input string s, input int gap, input int abort_at);
    exp_q.push_back(s);
    gap_q.push_back(gap);
    abort_q.push_back(abort_at);
  endtask

  task automatic pulse(input int d, input logic [7:0] data);
    @(negedge clk);
    tx_data  = data;
    tx_en[d] = 1'b1;
    @(posedge clk);
    #1 tx_en[d] = 1'b0;
  endtask

  // Monitor: a falling TX_STATUS starts a frame, checked cycle by cycle.
  initial begin : monitor
    int    idle_cnt;
    string s;
    int    gap;
    int    abort_at;
    bit    aborted;
    logic  b;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_status === 1'b1) begin
        idle_cnt++;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'(mon_status), 32'd1);
        for (int k = 0; k < 2000 && mon_status !== 1'b1; k++) @(negedge clk);
        idle_cnt = 0;
      end else begin
        s        = exp_q.pop_front();
        gap      = gap_q.pop_front();
        abort_at = abort_q.pop_front();
        aborted  = 1'b0;
        if (gap >= 0) chk("idle_gap", 32'(idle_cnt), 32'(gap));
        for (int c = 0; c < s.len() * 16; c++) begin
          if (c > 0) @(negedge clk);
          if (c == abort_at) begin
            aborted = 1'b1;
            break;
          end
          b = (s[c / 16] == "1");
          chk("frame_bit", {30'd0, mon_status, mon_tx}, {30'd0, 1'b0, b});
        end
        if (!aborted) begin
          @(negedge clk);
          chk("frame_end", {30'd0, mon_status, mon_tx}, 32'd3);
          idle_cnt = 1;
        end else begin
          idle_cnt = 0;
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, st, tx}, 32'hFF);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", {24'd0, st, tx}, 32'hFF);
    end

    sel = 2'd0;
    push("0101010101", -1, -1);
    pulse(0, 8'h55);
    repeat (200) @(negedge clk);

    sel = 2'd1;
    push("00111111111", -1, -1);
    pulse(1, 8'hFE);
    repeat (200) @(negedge clk);

    sel = 2'd2;
    push("00111111101", -1, -1);
    pulse(2, 8'hFE);
    repeat (200) @(negedge clk);

    // TX_EN held high: second frame starts one cycle after TX_STATUS rises
    sel = 2'd3;
    push("01100010111", -1, -1);
    push("01100010111", 1, -1);
    @(negedge clk);
    tx_data  = 8'hA3;
    tx_en[3] = 1'b1;
    @(posedge clk);
    repeat (177) @(posedge clk);
    #1 tx_en[3] = 1'b0;
    repeat (200) @(negedge clk);

    // Request during a frame is dropped; live TX_DATA changes are ignored
    sel = 2'd0;
    push("0111100001", -1, -1);
    pulse(0, 8'h0F);
    repeat (39) @(posedge clk);
    #1;
    tx_data  = 8'hF0;
    tx_en[0] = 1'b1;
    @(posedge clk);
    #1 tx_en[0] = 1'b0;
    repeat (200) @(negedge clk);

    // Asynchronous abort at cycle 70 of a frame
    push("0000000001", -1, 70);
    pulse(0, 8'h00);
    repeat (70) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_abort", {30'd0, mon_status, mon_tx}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {24'd0, st, tx}, 32'hFF);
    push("0001111001", -1, -1);
    pulse(0, 8'h3C);
    repeat (200) @(negedge clk);

    chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
